// File: rtl/fifo_read_logic_if.sv
// rtl/fifo_read_logic_if.sv - read-side handshake bundle between FIFO read logic and its consumer
//
// Purpose: groups the read-domain request, synchronized write pointer and the
//          read logic's outputs into one bundle.
// Ports (signals):
//   rinc          consumer -> read logic  read request, level-sensitive
//   rq2_waddr     consumer -> read logic  synchronized gray write pointer
//   rempty        read logic -> consumer  registered empty flag
//   read_en       read logic -> consumer  read strobe to FIFO memory
//   raddr         read logic -> consumer  memory read address
//   raddr_gray    read logic -> consumer  gray read pointer for the write domain
//   ralmost_empty read logic -> consumer  only with FIFO_READ_ALMOST_EMPTY_EN
//   rlevel        read logic -> consumer  only with FIFO_READ_ALMOST_EMPTY_EN
// Modports: master = consumer side, slave = fifo_read_logic.

interface fifo_read_logic_if #(
    parameter int PTR_SZ = 2
);
    logic              rinc;
    logic [PTR_SZ:0]   rq2_waddr;
    logic              rempty;
    logic              read_en;
    logic [PTR_SZ-1:0] raddr;
    logic [PTR_SZ:0]   raddr_gray;
`ifdef FIFO_READ_ALMOST_EMPTY_EN
    logic              ralmost_empty;
    logic [PTR_SZ:0]   rlevel;

    modport master (
        output rinc, rq2_waddr,
        input  rempty, read_en, raddr, raddr_gray, ralmost_empty, rlevel
    );
    modport slave (
        input  rinc, rq2_waddr,
        output rempty, read_en, raddr, raddr_gray, ralmost_empty, rlevel
    );
`else
    modport master (
        output rinc, rq2_waddr,
        input  rempty, read_en, raddr, raddr_gray
    );
    modport slave (
        input  rinc, rq2_waddr,
        output rempty, read_en, raddr, raddr_gray
    );
`endif
endinterface

// File: rtl/fifo_read_logic.sv
// rtl/fifo_read_logic.sv - read-domain pointer and empty-flag logic for the dual-clock gray FIFO
//
// Purpose: tracks the binary/gray read pointer, produces the read strobe and
//          memory address, and registers the empty flag against the
//          synchronized gray write pointer.
// Ports:
//   clk  read-domain clock, rising edge
//   rst  asynchronous active-low reset
//   rif  fifo_read_logic_if.slave (rinc, rq2_waddr in; rempty, read_en,
//        raddr, raddr_gray out; ralmost_empty, rlevel out with the option)
// Optional feature: FIFO_READ_ALMOST_EMPTY_EN adds the registered fill level
//          and almost-empty flag.

module fifo_read_logic #(
    parameter int PTR_SZ    = 2,
    parameter int AE_THRESH = 1
) (
    input  logic             clk,
    input  logic             rst,
    fifo_read_logic_if.slave rif
);

    typedef enum logic [1:0] {
        S_RST   = 2'd0,
        S_EMPTY = 2'd1,
        S_AVAIL = 2'd2
    } state_e;

    state_e          state_q, state_d;
    logic [PTR_SZ:0] rbin_q, rbin_d;
    logic [PTR_SZ:0] raddr_gray_q, raddr_gray_d;
    logic            rempty_q, rempty_d;
    logic            read_en;

    // Threshold outside 0..depth has no meaning; such a build carries this
    // marker scope so it is easy to spot in the elaborated hierarchy.
    if (AE_THRESH < 0 || AE_THRESH > (1 << PTR_SZ)) begin : g_ae_thresh_out_of_range
    end

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_RST;
        end else begin
            state_q <= state_d;
        end
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_RST:   state_d = S_EMPTY;
            S_EMPTY: if (!rempty_d) state_d = S_AVAIL;
            S_AVAIL: if (rempty_d)  state_d = S_EMPTY;
            default: state_d = S_RST;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    // Built only from registered state so the strobe never depends on the
    // asynchronous write pointer.
    always_comb begin
        read_en = rif.rinc & ~rempty_q & (state_q != S_RST);
    end

    // ---------------- pointers and empty flag ----------------
    always_comb begin
        rbin_d       = rbin_q + {{PTR_SZ{1'b0}}, read_en};
        raddr_gray_d = (rbin_d >> 1) ^ rbin_d;
        // Compare the post-read pointer with the current write pointer, so a
        // write landing alongside the last read keeps the FIFO non-empty.
        rempty_d     = (raddr_gray_d == rif.rq2_waddr);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rbin_q       <= '0;
            raddr_gray_q <= '0;
            rempty_q     <= 1'b1;
        end else begin
            rbin_q       <= rbin_d;
            raddr_gray_q <= raddr_gray_d;
            rempty_q     <= rempty_d;
        end
    end

    assign rif.read_en    = read_en;
    assign rif.raddr      = rbin_q[PTR_SZ-1:0];
    assign rif.raddr_gray = raddr_gray_q;
    assign rif.rempty     = rempty_q;

`ifdef FIFO_READ_ALMOST_EMPTY_EN
    localparam logic [PTR_SZ:0] AE_THRESH_P = AE_THRESH[PTR_SZ:0];

    logic [PTR_SZ:0] wbin;
    logic [PTR_SZ:0] rlevel_q, rlevel_d;
    logic            ralmost_empty_q, ralmost_empty_d;

    // Gray to binary: each binary bit is the XOR of all gray bits at or above it.
    always_comb begin
        wbin = '0;
        for (int i = 0; i <= PTR_SZ; i++) begin
            wbin[i] = ^(rif.rq2_waddr >> i);
        end
    end

    always_comb begin
        rlevel_d        = wbin - rbin_d;
        ralmost_empty_d = (rlevel_d <= AE_THRESH_P);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rlevel_q        <= '0;
            ralmost_empty_q <= 1'b1;
        end else begin
            rlevel_q        <= rlevel_d;
            ralmost_empty_q <= ralmost_empty_d;
        end
    end

    assign rif.rlevel        = rlevel_q;
    assign rif.ralmost_empty = ralmost_empty_q;
`endif

endmodule

// File: tb/tb_fifo_read_logic.sv
// tb/tb_fifo_read_logic.sv - directed self-checking bench for fifo_read_logic (optional checks under FIFO_READ_ALMOST_EMPTY_EN)

module tb_fifo_read_logic;

    localparam int PTR_SZ = 2;

    logic clk;
    logic rst;
    int   checks;
    int   failures;

    fifo_read_logic_if #(.PTR_SZ(PTR_SZ)) rif ();

    fifo_read_logic #(
        .PTR_SZ    (PTR_SZ),
        .AE_THRESH (1)
    ) dut (
        .clk (clk),
        .rst (rst),
        .rif (rif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and settle just after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [2:0] gray_lap1 [4];
        logic [2:0] gray_lap2 [4];
        gray_lap1 = '{3'd1, 3'd3, 3'd2, 3'd6};
        gray_lap2 = '{3'd7, 3'd5, 3'd4, 3'd0};
        checks    = 0;
        failures  = 0;

        // 1. reset and stall
        rst           = 1'b0;
        rif.rinc      = 1'b1;
        rif.rq2_waddr = '0;
        tick();
        tick();
        check("rst_rempty", 32'(rif.rempty), 32'd1);
        check("rst_read_en", 32'(rif.read_en), 32'd0);
        check("rst_raddr", 32'(rif.raddr), 32'd0);
        check("rst_gray", 32'(rif.raddr_gray), 32'd0);
`ifdef FIFO_READ_ALMOST_EMPTY_EN
        check("rst_ae", 32'(rif.ralmost_empty), 32'd1);
        check("rst_rlevel", 32'(rif.rlevel), 32'd0);
`endif
        rst = 1'b1;
        tick();
        check("stall1_rempty", 32'(rif.rempty), 32'd1);
        check("stall1_read_en", 32'(rif.read_en), 32'd0);
        tick();
        check("stall2_read_en", 32'(rif.read_en), 32'd0);
        check("stall2_gray", 32'(rif.raddr_gray), 32'd0);

        // 2. single entry
        rif.rinc      = 1'b0;
        rif.rq2_waddr = 3'd1;
        tick();
        check("single_rempty0", 32'(rif.rempty), 32'd0);
        rif.rinc = 1'b1;
        #1;
        check("single_read_en", 32'(rif.read_en), 32'd1);
        check("single_raddr0", 32'(rif.raddr), 32'd0);
        tick();
        rif.rinc = 1'b0;
        check("single_raddr1", 32'(rif.raddr), 32'd1);
        check("single_gray1", 32'(rif.raddr_gray), 32'd1);
        check("single_rempty1", 32'(rif.rempty), 32'd1);

        // 3. fill and drain from reset: write pointer gray 6 = four entries
        rst = 1'b0;
        #1;
        rst           = 1'b1;
        rif.rq2_waddr = 3'd6;
        rif.rinc      = 1'b1;
        tick();
        for (int i = 0; i < 4; i++) begin
            check($sformatf("drain_read_en%0d", i), 32'(rif.read_en), 32'd1);
            check($sformatf("drain_raddr%0d", i), 32'(rif.raddr), 32'(i));
            tick();
            check($sformatf("drain_gray%0d", i), 32'(rif.raddr_gray), 32'(gray_lap1[i]));
        end
        check("drain_rempty", 32'(rif.rempty), 32'd1);
        check("drain_raddr_end", 32'(rif.raddr), 32'd0);
        check("drain_read_en_end", 32'(rif.read_en), 32'd0);
        tick();
        check("drain_hold_read_en", 32'(rif.read_en), 32'd0);

        // 4. second lap: write pointer back to gray 0 (binary 8 mod 8)
        rif.rq2_waddr = 3'd0;
        tick();
        for (int i = 0; i < 4; i++) begin
            check($sformatf("lap2_read_en%0d", i), 32'(rif.read_en), 32'd1);
            check($sformatf("lap2_raddr%0d", i), 32'(rif.raddr), 32'(i));
            tick();
            check($sformatf("lap2_gray%0d", i), 32'(rif.raddr_gray), 32'(gray_lap2[i]));
        end
        check("lap2_rempty", 32'(rif.rempty), 32'd1);
        check("lap2_read_en_end", 32'(rif.read_en), 32'd0);

        // 5. write arrives in the same cycle as the last read
        rif.rinc      = 1'b0;
        rif.rq2_waddr = 3'd1;
        tick();
        rif.rinc = 1'b1;
        #1;
        check("simul_read_en0", 32'(rif.read_en), 32'd1);
        rif.rq2_waddr = 3'd3;
        tick();
        check("simul_rempty_held", 32'(rif.rempty), 32'd0);
        check("simul_read_en1", 32'(rif.read_en), 32'd1);
        check("simul_raddr1", 32'(rif.raddr), 32'd1);
        tick();
        check("simul_rempty_end", 32'(rif.rempty), 32'd1);
        check("simul_gray_end", 32'(rif.raddr_gray), 32'd3);
        check("simul_raddr_end", 32'(rif.raddr), 32'd2);

        // 6. asynchronous reset mid-cycle with rbin = 2
        #3;
        rst = 1'b0;
        #1;
        check("async_raddr", 32'(rif.raddr), 32'd0);
        check("async_gray", 32'(rif.raddr_gray), 32'd0);
        check("async_rempty", 32'(rif.rempty), 32'd1);
        check("async_read_en", 32'(rif.read_en), 32'd0);
        tick();
        rst           = 1'b1;
        rif.rinc      = 1'b0;
        rif.rq2_waddr = 3'd3;
        tick();
        check("post_rst_rempty", 32'(rif.rempty), 32'd0);
`ifdef FIFO_READ_ALMOST_EMPTY_EN
        check("ae_rlevel2", 32'(rif.rlevel), 32'd2);
        check("ae_flag0", 32'(rif.ralmost_empty), 32'd0);
`endif
        rif.rinc = 1'b1;
        tick();
        rif.rinc = 1'b0;
        check("post_rst_raddr", 32'(rif.raddr), 32'd1);
`ifdef FIFO_READ_ALMOST_EMPTY_EN
        check("ae_rlevel1", 32'(rif.rlevel), 32'd1);
        check("ae_flag1", 32'(rif.ralmost_empty), 32'd1);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fifo_read_logic.md
Name: fifo_read_logic

Overview:
Read-side pointer and flag logic for the dual-clock gray-pointer FIFO, and the counterpart of the write-side logic. It runs in the read clock domain and consumes the write pointer, already gray-coded and two-flop synchronized into this domain. It produces the memory read address, the read strobe, the registered empty flag, and the gray read pointer that is exported to the write domain's synchronizer.

Parameters:
PTR_SZ, 2, address width; FIFO depth = 2**PTR_SZ; pointers are PTR_SZ+1 bits, with the MSB used as the wrap bit.
AE_THRESH, 1, almost-empty threshold in entries (used only with the optional feature); valid range 0..2**PTR_SZ.

Ports:
clk  input  1  read-domain clock, rising edge.
rst  input  1  asynchronous active-low reset.
rinc  input  1  read request, level-sensitive; one entry is consumed per clk while high and not empty.
rq2_waddr  input  PTR_SZ+1  synchronized gray write pointer.
rempty  output  1  registered empty flag.
read_en  output  1  read strobe to the FIFO memory.
raddr  output  PTR_SZ  memory read address.
raddr_gray  output  PTR_SZ+1  registered gray read pointer, sent to the write domain.
ralmost_empty  output  1  present only with FIFO_READ_ALMOST_EMPTY_EN.
rlevel  output  PTR_SZ+1  present only with FIFO_READ_ALMOST_EMPTY_EN.

Behaviour:
- Reset (asynchronous, active-low):
  - rst low forces the following immediately, regardless of clk: rbin=0, raddr_gray=0, rempty=1, state=S_RST.
  - Outputs during and after reset: read_en=0, raddr=0; with the optional feature, ralmost_empty=1 and rlevel=0.
- State machine (2-bit current_state/next_state):
  - S_RST -> S_EMPTY, unconditionally on the first clk after rst is released. read_en is forced to 0 in this state.
  - S_EMPTY -> S_AVAIL when rempty_next=0; otherwise stays in S_EMPTY.
  - S_AVAIL -> S_EMPTY when rempty_next=1; otherwise stays in S_AVAIL.
- Read strobe:
  - read_en = rinc & ~rempty & (state != S_RST); combinational from registered values only.
  - A request while empty is ignored: no pointer change and no error.
- Pointers:
  - rbin_next = rbin + read_en, modulo 2**(PTR_SZ+1).
  - rgray_next = (rbin_next >> 1) ^ rbin_next.
  - rbin and raddr_gray are registered on clk.
  - raddr = rbin[PTR_SZ-1:0], so it wraps naturally from depth-1 to 0.
- Empty flag:
  - rempty_next = (rgray_next == rq2_waddr), registered into rempty.
  - A change on rq2_waddr is visible on rempty 1 clk later.
  - A read that consumes the last entry asserts rempty on the same edge that advances the pointer.
- Simultaneous events:
  - A new write arriving on rq2_waddr in the same cycle as the last read: rempty_next is evaluated against the new rq2_waddr, so rempty stays 0 if data remains.
- Full wrap: after 2**(PTR_SZ+1) reads the pointers return to 0. The wrap bit distinguishes lap parity; empty is declared only on full gray equality.
- Latency: raddr is valid for the entry under read in the cycle read_en=1. The memory is responsible for its own read latency.

Optional Feature:
Macro FIFO_READ_ALMOST_EMPTY_EN.
- Defined:
  - Adds the ralmost_empty and rlevel ports.
  - The wbin computation converts rq2_waddr from gray to binary combinationally (XOR prefix).
  - rlevel is registered each clk from the next-cycle pointer values: rlevel <= gray2bin(rq2_waddr) - rbin_next, in PTR_SZ+1-bit wrap arithmetic.
  - ralmost_empty is registered: ralmost_empty <= (gray2bin(rq2_waddr) - rbin_next) <= AE_THRESH.
  - With no read in a cycle, rbin_next = rbin and both outputs track rq2_waddr with the same 1-clk latency as rempty.
  - Both outputs update on every clk.
- Not defined: neither port exists, no gray-to-binary logic is built, and the core behaviour is identical.

Test Plan:
1. Reset and stall: hold rst=0, then release with rq2_waddr=0 and rinc=1 -> rempty=1, read_en=0, raddr=0, raddr_gray=0 for all cycles; state S_RST then S_EMPTY.
2. Single entry: set rq2_waddr=1 -> 1 clk later rempty=0. Pulse rinc for 1 clk -> read_en=1 that cycle; next edge raddr=1, raddr_gray=1, rempty=1.
3. Fill and drain (PTR_SZ=2): starting from reset, set rq2_waddr=6 (binary 4) and hold rinc=1.
   - Expect 4 read_en pulses at raddr 0,1,2,3.
   - raddr_gray goes 1,3,2,6.
   - Final raddr=0 and rempty=1.
   - rinc held high afterward gives read_en=0.
4. Second lap wrap: continue from case 3, set rq2_waddr=0 (binary 8 mod 8) and hold rinc=1 -> 4 reads, raddr_gray goes 7,5,4,0 and ends with rempty=1. This confirms the wrap bit.
5. Simultaneous write and last read: with one entry present and rinc=1, change rq2_waddr to add one entry in the same cycle -> rempty stays 0 and a second read_en follows.
6. Mid-operation reset, plus optional feature:
   - With rbin=2, drive rst low mid-cycle -> raddr=0, raddr_gray=0, rempty=1 immediately, without waiting for clk.
   - With FIFO_READ_ALMOST_EMPTY_EN defined, AE_THRESH=1 and rq2_waddr=3 (binary 2) -> rlevel=2 and ralmost_empty=0.
   - After one read -> rlevel=1 and ralmost_empty=1.
